// File: rtl/regfile_pkg.sv
// Shared state encodings and default geometry for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_DW = 32;
    localparam int DEF_AW = 5;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: zero gating, same-cycle write bypass and busy masking.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int NW       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic             active,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    input  logic [NW-1:0]    we,
    input  logic [NW*AW-1:0] waddr,
    input  logic [NW*DW-1:0] wdata,
    input  logic [DW-1:0]    arr_data,
    input  logic             busy_bit,
    output logic [DW-1:0]    rdata,
    output logic             rbusy
);

    logic          hit;
    logic [DW-1:0] byp;
    logic          zero;

    // Ascending scan so the highest-numbered matching write port is the one forwarded.
    always_comb begin
        hit = 1'b0;
        byp = '0;
        for (int k = 0; k < NW; k++) begin
            if (we[k] && (waddr[k*AW +: AW] == raddr)) begin
                hit = 1'b1;
                byp = wdata[k*DW +: DW];
            end
        end
    end

    assign zero  = !active || !re || ((ZERO_REG != 0) && (raddr == '0));
    assign rdata = zero ? '0 : (hit ? byp : arr_data);
    assign rbusy = !zero && busy_bit && !hit;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-through bypass, busy scoreboard and a
// post-reset sequencer that clears one entry per cycle before the file is usable.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int NR       = 2,
    parameter int NW       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NW-1:0]    we,
    input  logic [NW*AW-1:0] waddr,
    input  logic [NW*DW-1:0] wdata,
    input  logic [NR-1:0]    re,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata,
    output logic [NR-1:0]    rbusy,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    output logic             ready
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busy;
    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (cnt == AW'(DEPTH - 1)) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    // Reset is folded in so readers see a dead file in the very cycle rst rises.
    always_comb begin
        ready = (state == ST_RUN) && !rst;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                regs[cnt] <= '0;
            end else begin
                for (int k = 0; k < NW; k++) begin
                    if (we[k] && !((ZERO_REG != 0) && (waddr[k*AW +: AW] == '0))) begin
                        regs[waddr[k*AW +: AW]] <= wdata[k*DW +: DW];
                    end
                end
            end
        end
    end

    // Completion clears first, then issue sets, so a same-cycle set on that entry wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else if (state == ST_INIT) begin
            busy[cnt] <= 1'b0;
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (we[k]) begin
                    busy[waddr[k*AW +: AW]] <= 1'b0;
                end
            end
            if (set_en && !((ZERO_REG != 0) && (set_addr == '0))) begin
                busy[set_addr] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = raddr[i*AW +: AW];

        regfile_rd_port #(
            .DW      (DW),
            .AW      (AW),
            .NW      (NW),
            .ZERO_REG(ZERO_REG)
        ) u_rd (
            .active  (ready),
            .re      (re[i]),
            .raddr   (ra),
            .we      (we),
            .waddr   (waddr),
            .wdata   (wdata),
            .arr_data(regs[ra]),
            .busy_bit(busy[ra]),
            .rdata   (rdata[i*DW +: DW]),
            .rbusy   (rbusy[i])
        );
    end

endmodule
